// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain block: default word width and the
// occupancy encoding of the 2-entry output buffer.
package fifo_pkg;

    localparam int DW_DEF = 8;

    // Output buffer occupancy; doubles as the buffer's FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer (ring of two words, pointers wrap modulo 2).
// Occupancy is the FSM state and is exported on the occupancy port.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output occ_e          occupancy
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    occ_e          occ_q;
    occ_e          occ_d;

    assign occupancy = occ_q;
    assign dout      = mem[rd_ptr];

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = (occ_q == EMPTY) ? ONE : TWO;
            2'b01:   occ_d = (occ_q == TWO) ? ONE : EMPTY;
            default: occ_d = occ_q;
        endcase
    end

    // State, storage and pointers; reset clears the words so the head reads 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            assert (!(push && !pop && occ_q == TWO));
            assert (!(pop && occ_q == EMPTY));
            occ_q <= occ_d;
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// Drains a synchronous FIFO (read data one cycle after the read strobe) into
// a valid/ready stream through a 2-entry buffer.
// Optional feature: define FIFO_DRAIN_CNT_EN to add the 16-bit word_cnt pop
// counter output.
//
// Handshake: a word transfers on every rising edge where m_valid and m_ready
// are both 1; m_valid never depends on m_ready, and once raised it stays high
// with m_data unchanged until that transfer happens.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
`ifdef FIFO_DRAIN_CNT_EN
    output logic [15:0]   word_cnt,
`endif
    input  logic          m_ready
);

    occ_e       occupancy;
    logic [1:0] occ_bits;
    logic [1:0] load;
    logic       inflight;
    logic       pop;

    assign occ_bits = occupancy;
    assign m_valid  = (occupancy != EMPTY);
    assign pop      = m_valid & m_ready;

    // Words that will sit in the buffer after this edge; a new read is only
    // safe while that leaves room for the word it brings two edges later.
    // Never exceeds 2 (in-flight implies occupancy <= 1), so 2 bits suffice.
    assign load    = occ_bits + {1'b0, inflight} - {1'b0, pop};
    assign fifo_rd = rst & en & ~fifo_empty & (load < 2'd2);

    // Read data arrives one cycle after the strobe; remember to capture it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= 1'b0;
        end else begin
            assert ({1'b0, occ_bits} + {2'b00, inflight} <= 3'd2);
            inflight <= fifo_rd;
        end
    end

    skid_buf2 #(
        .DW(DW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .pop      (pop),
        .din      (fifo_dout),
        .dout     (m_data),
        .occupancy(occupancy)
    );

`ifdef FIFO_DRAIN_CNT_EN
    // Count delivered words, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt <= 16'd0;
        end else if (pop) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a queue-based FIFO model feeds the DUT; a timestamped
// scoreboard predicts fifo_rd, m_valid and m_data every cycle.
module tb_fifo_drain;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0]   word_cnt;
`endif

    always #5 clk = ~clk;

    fifo_drain #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .m_valid   (m_valid),
        .m_data    (m_data),
`ifdef FIFO_DRAIN_CNT_EN
        .word_cnt  (word_cnt),
`endif
        .m_ready   (m_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait expired without the expected event at %0t", name, $time);
    endtask

    // Environment: the FIFO contents and what reached the downstream side.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] deliv_q[$];
    int            rd_count = 0;

    // Model: words read but not yet delivered, each with the first cycle it
    // may appear on m_data (two edges after its read strobe).
    logic [DW-1:0] exp_q[$];
    int            avail_q[$];
    int            outstanding = 0;
    int            cyc = 0;
    logic [15:0]   cnt_model = 16'd0;
    bit            rd_exp_c = 1'b0;
    bit            mv_exp_c = 1'b0;
    bit            pop_exp_c = 1'b0;
    bit            mon_on = 1'b0;

    task automatic push_word(input logic [DW-1:0] w);
        src_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Advance the model and the FIFO on every edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            avail_q.delete();
            outstanding = 0;
            cnt_model   = 16'd0;
        end else begin
            if (pop_exp_c) begin
                void'(exp_q.pop_front());
                void'(avail_q.pop_front());
                outstanding--;
                cnt_model++;
            end
            if (rd_exp_c) begin
                exp_q.push_back(src_q[0]);
                avail_q.push_back(cyc + 1);
                outstanding++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) deliv_q.push_back(m_data);
        end
        if (fifo_rd === 1'b1 && src_q.size() > 0) begin
            fifo_dout <= src_q.pop_front();
            rd_count++;
        end
        fifo_empty <= (src_q.size() == 0);
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        mv_exp_c  = (avail_q.size() > 0) && (avail_q[0] <= cyc);
        pop_exp_c = mv_exp_c && m_ready;
        rd_exp_c  = rst && en && (src_q.size() > 0) && ((outstanding - int'(pop_exp_c)) < 2);
        if (mon_on) begin
            chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, rd_exp_c});
            chk("m_valid", {31'd0, m_valid}, {31'd0, mv_exp_c});
            if (mv_exp_c) chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
`ifdef FIFO_DRAIN_CNT_EN
            chk("word_cnt", {16'd0, word_cnt}, {16'd0, cnt_model});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= budget) timeout_fail(name);
        step();
    endtask

    task automatic do_reset(input int n, input bit flush);
        rst = 1'b0;
        if (flush) begin
            src_q.delete();
            fifo_empty = 1'b1;
        end
        repeat (n) step();
        rst = 1'b1;
    endtask

    initial begin
        int base;
        int t;
        int pushed;
        rst = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = '0;

        // Reset with three words waiting in the FIFO.
        push_word(8'hA0);
        push_word(8'hA1);
        push_word(8'hA2);
        step();
        mon_on = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_first_rd", {31'd0, fifo_rd}, 32'd1);
        chk("rst_rel_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_rel_m_data", {24'd0, m_data}, 32'd0);
        wait_drain("rst_drain", 40);
        chk("rst_deliv_n", deliv_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < deliv_q.size(); i++)
            chk("rst_deliv", {24'd0, deliv_q[i]}, 32'hA0 + i);

        // Single-word latency.
        deliv_q.delete();
        step();
        push_word(8'h11);
        @(negedge clk);
        chk("lat_rd_n", {31'd0, fifo_rd}, 32'd1);
        @(negedge clk);
        chk("lat_valid_n1", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid_n2", {31'd0, m_valid}, 32'd1);
        chk("lat_data_n2", {24'd0, m_data}, 32'h11);
        @(negedge clk);
        chk("lat_idle_valid", {31'd0, m_valid}, 32'd0);
        chk("lat_idle_rd", {31'd0, fifo_rd}, 32'd0);
        step();

        // Streaming 16 words with m_ready held high.
        for (int i = 0; i < 16; i++) push_word(i[7:0]);
        t = 0;
        @(negedge clk);
        while (m_valid !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) timeout_fail("stream_start");
        for (int i = 0; i < 16; i++) begin
            chk("stream_valid", {31'd0, m_valid}, 32'd1);
            chk("stream_data", {24'd0, m_data}, i);
            @(negedge clk);
        end
        chk("stream_end", {31'd0, m_valid}, 32'd0);
        step();

        // Backpressure: five words, downstream stalled.
        deliv_q.delete();
        m_ready = 1'b0;
        base = rd_count;
        for (int i = 0; i < 5; i++) push_word(i[7:0]);
        repeat (10) @(negedge clk);
        chk("bp_rd_pulses", rd_count - base, 32'd2);
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_data", {24'd0, m_data}, 32'h00);
        step();
        m_ready = 1'b1;
        wait_drain("bp_drain", 40);
        chk("bp_deliv_n", deliv_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < deliv_q.size(); i++)
            chk("bp_deliv", {24'd0, deliv_q[i]}, i);

        // Enable dropped after three reads, then restored.
        deliv_q.delete();
        base = rd_count;
        for (int i = 0; i < 8; i++) push_word(8'h40 + i[7:0]);
        t = 0;
        while (rd_count - base < 3 && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) timeout_fail("en_reads");
        en = 1'b0;
        repeat (8) step();
        chk("en_off_reads", rd_count - base, 32'd3);
        chk("en_off_deliv", deliv_q.size(), 32'd3);
        en = 1'b1;
        wait_drain("en_drain", 40);
        chk("en_deliv_n", deliv_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < deliv_q.size(); i++)
            chk("en_deliv", {24'd0, deliv_q[i]}, 32'h40 + i);

        // Randomized traffic with occasional mid-stream reset.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (rst == 1'b0) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                src_q.delete();
                fifo_empty = 1'b1;
            end
            en = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 9) < 7);
            if (src_q.size() < 6 && $urandom_range(0, 9) < 5) push_word($urandom_range(0, 255));
        end
        step();
        rst = 1'b1;
        en = 1'b1;
        m_ready = 1'b1;
        wait_drain("rand_drain", 60);

`ifdef FIFO_DRAIN_CNT_EN
        // Counter wrap after 65537 pops, then reset mid-stream.
        do_reset(1, 1'b1);
        pushed = 0;
        t = 0;
        while ((pushed < 65537 || src_q.size() != 0 || exp_q.size() != 0) && t < 70000) begin
            if (pushed < 65537 && src_q.size() < 3) begin
                push_word(pushed[7:0]);
                pushed++;
            end
            step();
            t++;
        end
        if (t >= 70000) timeout_fail("cnt_stream");
        step();
        chk("cnt_wrap", {16'd0, word_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) push_word(i[7:0]);
        repeat (4) step();
        do_reset(1, 1'b1);
        @(negedge clk);
        chk("cnt_reset", {16'd0, word_cnt}, 32'd0);
        step();
`else
        pushed = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width matching the FIFO word.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port en  input  1  drain enable; 0 suppresses new FIFO reads.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag (combinational from FIFO count).
REQ-006 SHALL have port fifo_dout  input  DW  FIFO read data, valid the cycle after an accepted read.
REQ-007 SHALL have port fifo_rd  output  1  FIFO read strobe.
REQ-008 SHALL have port m_valid  output  1  downstream data valid.
REQ-009 SHALL have port m_data  output  DW  downstream data.
REQ-010 SHALL have port m_ready  input  1  downstream accept.

Function
REQ-011 SHALL hold a 2-entry in-order output buffer plus one in-flight flag (inflight), giving states EMPTY, ONE and TWO (buffer occupancy).
REQ-012 SHALL assert fifo_rd combinationally iff en=1, fifo_empty=0 and (occupancy + inflight - pop) < 2, where pop = m_valid & m_ready.
REQ-013 SHALL set inflight=1 on the edge where fifo_rd=1, and clear it on the next edge unless fifo_rd is asserted again.
REQ-014 SHALL capture fifo_dout into the buffer tail on every edge where inflight=1.
REQ-015 SHALL drive m_valid = (occupancy != 0) and m_data = buffer head.
REQ-016 SHALL remove the head on an edge where m_valid & m_ready.
REQ-017 SHALL keep occupancy unchanged on a simultaneous capture and pop, with the captured word becoming the tail.
REQ-018 SHALL give a latency of 2 cycles from fifo_rd to m_valid when the buffer is EMPTY, and sustain 1 word/cycle while m_ready=1 and the FIFO is non-empty.
REQ-019 SHALL keep m_data stable while m_valid=1 and m_ready=0, and SHALL never drop m_valid without a pop.
REQ-020 SHALL issue no fifo_rd when occupancy=2 and no pop occurs; no word is ever lost or duplicated.
REQ-021 SHALL, when en falls, complete any in-flight capture and keep delivering buffered words.
REQ-022 SHALL preserve FIFO order exactly.
REQ-023 SHALL use buffer index wrap-around modulo 2.
REQ-024 SHALL keep occupancy arithmetic in 2 bits, saturating as an assertion error and never by overflow.

Reset
REQ-025 SHALL, on an edge with rst=0, clear occupancy, inflight and the buffer pointers, and drive m_valid=0, fifo_rd=0 and m_data=0.
REQ-026 SHALL, on reset mid-operation, discard in-flight and buffered words; the system resets the FIFO from the same rst.
REQ-027 SHALL assert fifo_rd no earlier than the first edge after rst returns to 1.

Configuration
REQ-028 SHALL, with FIFO_DRAIN_CNT_EN defined, add output word_cnt (16 bits) that counts pops, wraps 0xFFFF->0, and resets to 0.
REQ-029 SHALL, with FIFO_DRAIN_CNT_EN undefined, have no word_cnt port or logic, leaving all other behaviour identical.

Structure
REQ-030 SHALL take the DW default constant and the occupancy state enum (EMPTY/ONE/TWO) from shared package fifo_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module skid_buf2 (push, pop, din, dout, occupancy), with fifo_drain holding the read-issue logic.

Verification
REQ-032 SHALL cover reset: rst=0 for 2 cycles with FIFO holding 3 words -> m_valid=0, fifo_rd=0, m_data=0; first fifo_rd on the first edge after rst=1.
REQ-033 SHALL cover basic latency: FIFO loaded 0x11, en=1, m_ready=1 -> fifo_rd in cycle N, m_valid=1 with m_data=0x11 in cycle N+2, then empty and idle.
REQ-034 SHALL cover streaming: 16 words 0x00..0x0F, m_ready=1 -> 16 consecutive m_valid cycles in order, no gaps after the first.
REQ-035 SHALL cover backpressure: 5 words, m_ready=0 for 10 cycles -> exactly 2 fifo_rd pulses, m_data=0x00 stable; on m_ready=1 remaining 0x01..0x04 delivered in order.
REQ-036 SHALL cover en toggling: en=0 mid-stream after 3 reads -> no further fifo_rd, 3 words delivered, then resume on en=1 without loss.
REQ-037 SHALL cover the counter with FIFO_DRAIN_CNT_EN: word_cnt preset by 65535 pops, then 2 more pops -> word_cnt=1; reset mid-stream -> word_cnt=0.
